// File: rtl/if_fetch_queue_pkg.sv
// Shared definitions for the instruction-fetch stage: next-PC opcodes and the
// redirect-taken decision used by the fetch top level.
package if_fetch_queue_pkg;

  typedef enum logic [1:0] {
    NPC_SEQ  = 2'b00,
    NPC_BR   = 2'b01,
    NPC_JAL  = 2'b10,
    NPC_JALR = 2'b11
  } npc_op_e;

  // A control-flow redirect only bites for jumps or branches whose condition holds.
  function automatic logic redir_taken(input logic vld, input logic [1:0] op, input logic cond);
    return vld && (op == NPC_JAL || op == NPC_JALR || (op == NPC_BR && cond));
  endfunction

endpackage

// File: rtl/if_fetch_queue_queue.sv
// Prefetch queue: circular buffer of {inst, pc} words with push/pop/flush,
// occupancy count and head outputs.
module if_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [W-1:0]                 wdata,
  input  logic                         pop,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         head_valid,
  output logic [W-1:0]                 head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_pop, do_push, wr_en;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL) || do_pop);
  assign wr_en   = rst && !flush && do_push;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is not reset; head_valid gates every use of it.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

  assign head_valid = (count != '0);
  assign head       = mem[rd_ptr];

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: PC register, redirect target mux, one-outstanding
// synchronous IMEM read and a prefetch queue feeding decode over valid/ready.
module if_fetch_queue
  import if_fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              IMEM_AW  = 14,
  parameter int              QDEPTH   = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                redir_valid,
  input  logic [1:0]          npc_op,
  input  logic                br,
  input  logic [XLEN-1:0]     redir_base,
  input  logic [XLEN-1:0]     offset,
  output logic                imem_en,
  output logic [IMEM_AW-1:0]  imem_addr,
  input  logic [31:0]         imem_rdata,
  output logic                inst_valid,
  input  logic                inst_ready,
  output logic [31:0]         inst,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc4
);

  localparam int CW = $clog2(QDEPTH+1);
  localparam logic [CW:0] QD = (CW+1)'(QDEPTH);

  logic [XLEN-1:0]    fetch_pc, tag, sum, target;
  logic               inflight, take, pop, issue, push;
  logic [CW-1:0]      count;
  logic [CW:0]        occ;
  logic               q_valid;
  logic [31+XLEN:0]   q_head;

  assign pop  = inst_valid && inst_ready;
  assign take = redir_taken(redir_valid, npc_op, br);
  assign sum  = redir_base + offset;
  assign target = (npc_op == NPC_JALR) ? {sum[XLEN-1:1], 1'b0} : sum;

  // Slots already spoken for: queued words plus the read in flight, less the one leaving now.
  assign occ   = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign issue = rst && !take && (occ < QD);
  // A redirect kills the word returning this cycle.
  assign push  = inflight && !take;

  assign imem_en   = issue;
  assign imem_addr = fetch_pc[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      tag      <= '0;
    end else begin
      inflight <= issue;
      if (issue) tag <= fetch_pc;
      if (take)       fetch_pc <= target;
      else if (issue) fetch_pc <= fetch_pc + XLEN'(4);
    end
  end

  if_queue #(.W(32+XLEN), .DEPTH(QDEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .wdata      ({imem_rdata, tag}),
    .pop        (pop),
    .flush      (take),
    .count      (count),
    .head_valid (q_valid),
    .head       (q_head)
  );

  assign inst_valid = q_valid;
  assign inst       = q_valid ? q_head[31+XLEN:XLEN] : '0;
  assign pc         = q_valid ? q_head[XLEN-1:0] : '0;
  assign pc4        = q_valid ? q_head[XLEN-1:0] + XLEN'(4) : '0;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: stimulus pushes hand-computed delivery PCs
// into a scoreboard; a monitor pops and checks each accepted head.
module tb_if_fetch_queue;
  import if_fetch_queue_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redir_valid = 1'b0;
  logic [1:0]  npc_op = 2'b00;
  logic        br = 1'b0;
  logic [31:0] redir_base = '0;
  logic [31:0] offset = '0;
  logic        imem_en;
  logic [13:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst, pc, pc4;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_pc;

  if_fetch_queue #(.XLEN(32), .IMEM_AW(14), .QDEPTH(2), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redir_valid(redir_valid), .npc_op(npc_op), .br(br),
    .redir_base(redir_base), .offset(offset), .imem_en(imem_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc), .pc4(pc4)
  );

  always #5 clk = ~clk;

  // IMEM: word contents are a tag plus the word address; junk when not strobed.
  always @(posedge clk) imem_rdata <= imem_en ? (32'hC0DE_0000 | {18'd0, imem_addr}) : 32'hBAD0_BAD0;

  function automatic logic [31:0] exp_inst(input logic [31:0] p);
    return 32'hC0DE_0000 | {18'd0, p[15:2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic rdy, input logic v, input logic [1:0] op,
                       input logic b, input logic [31:0] base, input logic [31:0] off);
    @(negedge clk);
    rst = r; inst_ready = rdy; redir_valid = v; npc_op = op; br = b;
    redir_base = base; offset = off;
    #1;
  endtask

  task automatic cyc(input logic r, input logic rdy);
    drive(r, rdy, 1'b0, NPC_SEQ, 1'b0, 32'h0, 32'h0);
  endtask

  always @(negedge clk) begin
    #2;
    if (rst && inst_valid && inst_ready) begin
      if (sb.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL pop_unexpected: got pc %h, expected no delivery", pc);
      end else begin
        exp_pc = sb.pop_front();
        chk("head_pc", pc, exp_pc);
        chk("head_inst", inst, exp_inst(exp_pc));
        chk("head_pc4", pc4, exp_pc + 32'd4);
      end
    end
  end

  initial begin
    // Reset and streaming
    repeat (3) cyc(1'b0, 1'b0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_imem_en", 32'(imem_en), 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_pc4", pc4, 32'h0);
    chk("rst_inst", inst, 32'h0);
    for (int i = 0; i < 4; i++) sb.push_back(32'(i * 4));
    cyc(1'b1, 1'b1);
    chk("first_imem_en", 32'(imem_en), 32'd1);
    chk("first_addr", 32'(imem_addr), 32'h0);
    cyc(1'b1, 1'b1);
    chk("latency_valid", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b1);
      chk("stream_nobubble", 32'(inst_valid), 32'd1);
    end
    repeat (3) cyc(1'b0, 1'b0);

    // Backpressure with head held at pc 4
    for (int i = 0; i < 5; i++) sb.push_back(32'(i * 4));
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    chk("bp_first_pc", pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0);
      chk("bp_hold_pc", pc, 32'h4);
      chk("bp_imem_en", 32'(imem_en), 32'd0);
    end
    cyc(1'b1, 1'b1);
    chk("bp_release_en", 32'(imem_en), 32'd1);
    chk("bp_release_addr", 32'(imem_addr), 32'h3);
    repeat (3) cyc(1'b1, 1'b1);

    // Taken branch drops queued 0x14 and in-flight 0x18
    drive(1'b1, 1'b0, 1'b1, NPC_BR, 1'b1, 32'h10, 32'h20);
    chk("br_head_pc", pc, 32'h14);
    chk("br_take_en", 32'(imem_en), 32'd0);
    sb.push_back(32'h30); sb.push_back(32'h34);
    cyc(1'b1, 1'b1);
    chk("br_flush_valid", 32'(inst_valid), 32'd0);
    chk("br_target_addr", 32'(imem_addr), 32'hC);
    cyc(1'b1, 1'b1);
    chk("br_gap_valid", 32'(inst_valid), 32'd0);
    repeat (2) cyc(1'b1, 1'b1);
    sb.push_back(32'h38); sb.push_back(32'h3C);
    drive(1'b1, 1'b1, 1'b1, NPC_BR, 1'b0, 32'h10, 32'h20);
    chk("br_nt_en", 32'(imem_en), 32'd1);
    cyc(1'b1, 1'b1);

    // JALR clears bit 0; JAL wraps and overlaps a pop
    sb.push_back(32'h104); sb.push_back(32'h108);
    drive(1'b1, 1'b0, 1'b1, NPC_JALR, 1'b0, 32'h101, 32'h4);
    cyc(1'b1, 1'b1);
    chk("jalr_addr", 32'(imem_addr), 32'h41);
    repeat (3) cyc(1'b1, 1'b1);
    sb.push_back(32'h10C); sb.push_back(32'h8); sb.push_back(32'hC);
    drive(1'b1, 1'b1, 1'b1, NPC_JAL, 1'b0, 32'hFFFF_FFF8, 32'h10);
    cyc(1'b1, 1'b1);
    chk("jal_flush_valid", 32'(inst_valid), 32'd0);
    chk("jal_addr", 32'(imem_addr), 32'h2);
    repeat (3) cyc(1'b1, 1'b1);

    // PC wrap at the top of the address space
    sb.push_back(32'h10); sb.push_back(32'hFFFF_FFFC); sb.push_back(32'h0);
    drive(1'b1, 1'b1, 1'b1, NPC_JAL, 1'b0, 32'hFFFF_FFF0, 32'hC);
    cyc(1'b1, 1'b1);
    chk("wrap_addr", 32'(imem_addr), 32'h3FFF);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("wrap_pc4", pc4, 32'h0);
    cyc(1'b1, 1'b1);

    // Misaligned JALR target is kept as-is
    sb.push_back(32'h4); sb.push_back(32'h202); sb.push_back(32'h206);
    drive(1'b1, 1'b1, 1'b1, NPC_JALR, 1'b0, 32'h202, 32'h0);
    cyc(1'b1, 1'b1);
    chk("misalign_addr", 32'(imem_addr), 32'h80);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    chk("misalign_pc", pc, 32'h202);
    cyc(1'b1, 1'b1);

    // Reset while full with a redirect pending
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    chk("full_en", 32'(imem_en), 32'd0);
    chk("full_valid", 32'(inst_valid), 32'd1);
    drive(1'b0, 1'b0, 1'b1, NPC_JAL, 1'b0, 32'h1000, 32'h0);
    chk("midrst_en_now", 32'(imem_en), 32'd0);
    cyc(1'b0, 1'b0);
    chk("midrst_valid", 32'(inst_valid), 32'd0);
    chk("midrst_en", 32'(imem_en), 32'd0);
    sb.push_back(32'h0); sb.push_back(32'h4);
    cyc(1'b1, 1'b1);
    chk("restart_en", 32'(imem_en), 32'd1);
    chk("restart_addr", 32'(imem_addr), 32'h0);
    repeat (3) cyc(1'b1, 1'b1);
    repeat (2) cyc(1'b1, 1'b0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
